// File: rtl/tx_scheduler.sv
// Two-requester round-robin scheduler driving the UART transmitter load/transmit_en handshake.
// Optional BUSY watchdog compiled in with `define TX_SCHED_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module tx_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] char_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] char_b,
  output logic       ack_b,
  output logic       load,
  output logic [7:0] parallel_in,
  output logic       transmit_en,
  input  logic       char_sent,
  output logic       busy,
  output logic       grant,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("tx_scheduler: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state;
  logic   last_grant;
  logic   win;
  logic   wd_expire;

  // B wins when it is the only requester, or when both request and A went last.
  assign win = req_b & (~req_a | ~last_grant);

`ifdef TX_SCHED_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd_cnt;

  // Fires in the BUSY cycle whose increment would reach the limit.
  assign wd_expire = (wd_cnt + 8'd1) == LIMIT;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking = would make ordering matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      parallel_in <= 8'h00;
      load        <= 1'b0;
      transmit_en <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      busy        <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
      wd_cnt      <= 8'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; only the BUSY exit raises them.
      ack_a <= 1'b0;
      ack_b <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req_a | req_b) begin
            grant       <= win;
            parallel_in <= win ? char_b : char_a;
            load        <= 1'b1;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          load        <= 1'b0;
          transmit_en <= 1'b1;
          state       <= S_START;
        end
        S_START: begin
          transmit_en <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
          wd_cnt      <= 8'd0;
`endif
          state       <= S_BUSY;
        end
        S_BUSY: begin
          if (char_sent || wd_expire) begin
            ack_a <= ~grant;
            ack_b <= grant;
            state <= S_DONE;
          end
`ifdef TX_SCHED_TIMEOUT_EN
          // A frame end in the same cycle as expiry counts as a normal completion.
          timeout_err <= ~char_sent & wd_expire;
          if (!char_sent) wd_cnt <= wd_cnt + 8'd1;
`endif
        end
        S_DONE: begin
          busy       <= 1'b0;
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Two-requester round-robin scheduler for the serial transmitter. Accepts 8-bit characters from two independent producers (A and B), grants the shared transmitter to one at a time, sequences its `load` → `transmit_en` handshake, waits for `char_sent`, then acknowledges the winning producer. Sits between the character sources and the transmitter in the UART transmit path.

## Interface
- `TIMEOUT_CYCLES`, default 64: BUSY-state watchdog limit, in cycles.
  - Legal range 1..255.
  - Used only when `TX_SCHED_TIMEOUT_EN` is defined.
- `clk` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_a` in 1: requester A has a character. Level; held until `ack_a`.
- `char_a` in 8: A's character. Stable while `req_a` is high.
- `ack_a` out 1: one-cycle pulse when A's character has finished transmitting.
- `req_b`, `char_b`, `ack_b`: same as the A ports, for requester B.
- `load` out 1: to transmitter; captures `parallel_in`.
- `parallel_in` out 8: to transmitter; the granted character.
- `transmit_en` out 1: to transmitter; starts the shift-out.
- `char_sent` in 1: from transmitter; level, set at end of frame, cleared when the transmitter accepts `transmit_en`.
- `busy` out 1: state ≠ IDLE.
- `grant` out 1: owner of the current transfer, 0 = A, 1 = B. Meaningful only while `busy`.
- `timeout_err` out 1: one-cycle pulse, coincident with the ack, when a transfer was aborted by the watchdog.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.**
  - `load`, `transmit_en`, `ack_a`, `ack_b`, `busy`, `grant`, `timeout_err` = 0.
  - `parallel_in` = 8'h00.
  - Internal `last_grant` = 1, so A wins the first contention.
  - State = IDLE.
- **IDLE → LOAD**, when `req_a | req_b`.
  - Winner: the sole requester, or, if both request, `!last_grant`.
  - Registers `grant` and `parallel_in` (the winner's character).
  - Asserts `load` for the LOAD cycle.
- **LOAD → START** (unconditional).
  - `load` = 0, `transmit_en` = 1 for the START cycle.
- **START → BUSY** (unconditional).
  - `transmit_en` = 0.
  - Watchdog counter cleared.
- **BUSY → DONE**, when `char_sent` = 1.
- **DONE → IDLE** (unconditional).
  - The `ack` of the granted requester = 1 for the DONE cycle.
  - `last_grant` ← `grant`.
- **Stale `char_sent`.** `char_sent` is ignored outside BUSY. A stale high level left from the previous frame is cleared by the transmitter on the edge ending START, so BUSY never sees it.
- **Requester drops `req` mid-transfer.** Ignored; the transfer completes and the ack is still pulsed.
- **Requester protocol.** The requester deasserts `req` (or presents its next character) on the edge where it samples `ack` high. IDLE re-arbitrates on the cycle after DONE.
- **Fairness.** Under continuous requests from both A and B, grants alternate A, B, A, …
- **Reset mid-operation.** Asynchronous return to IDLE with all outputs at their reset values. An in-flight character is abandoned with no ack.

## Timing
- IDLE-sampled request → `load` high: 1 cycle.
- `load` → `transmit_en`: 1 cycle.
- `transmit_en` → BUSY: 1 cycle.
- With the standard transmitter (16 shift cycles), `char_sent` is seen in the 17th BUSY cycle.
- Request sampled in cycle 0 → `ack` in cycle 20. Back-to-back characters every 21 cycles.
- Watchdog (when compiled in):
  - 8-bit counter, increments each BUSY cycle with `char_sent` = 0.
  - On reaching `TIMEOUT_CYCLES`: BUSY → DONE; ack and `timeout_err` pulse together.
  - If `char_sent` = 1 and the limit are reached in the same cycle, `char_sent` wins and `timeout_err` = 0.

## Configuration
- **`TX_SCHED_TIMEOUT_EN` defined:**
  - Watchdog counter and `TIMEOUT_CYCLES` abort path are present.
  - `timeout_err` is driven as described under Timing.
- **`TX_SCHED_TIMEOUT_EN` undefined:**
  - No counter; BUSY waits indefinitely for `char_sent`.
  - `timeout_err` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Single A request.** Reset; `req_a` = 1, `char_a` = 8'h41.
  - → `load` with `parallel_in` = 8'h41 in cycle 1, `transmit_en` in cycle 2.
  - → `ack_a` single pulse in cycle 20; `grant` = 0; `ack_b` never high.
- **Simultaneous requests.** `req_a` and `req_b` rise in the same cycle after reset, `char_a` = 8'h55, `char_b` = 8'hAA.
  - → A is served first (8'h55), then B (8'hAA).
  - → Acks 21 cycles apart.
- **Continuous contention.** Both requesters held high for 6 characters.
  - → Grant sequence A, B, A, B, A, B.
  - → `busy` low for exactly one cycle between transfers.
- **Stale `char_sent`.** Hold `char_sent` = 1 in IDLE.
  - → No ack.
  - → After a new request, the ack waits for the new frame's `char_sent` (still cycle 20).
- **Reset mid-transfer.** Assert `reset` during BUSY.
  - → All outputs 0 immediately (asynchronously).
  - → No ack; a subsequent `req_b` alone is granted to B normally.
- **Stuck transmitter.** With `TX_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 10, `char_sent` stuck at 0.
  - → `ack` and `timeout_err` pulse together 10 cycles after BUSY entry.
  - → Without the macro, no ack ever occurs.
